sweep_peak_detector: RTL
========================

// Module: sweep_peak_detector
// PURPOSE
//  Downstream consumer of the phase_detector I/Q results during a frequency_sweeper run.
//  - Per valid point: forms magnitude approx |I|+|Q| style (max + min/2).
//  - Tracks the peak magnitude and the DDS tuning word at which it occurred.
//  - At sweep end, presents one summary record (peak_freq, peak_mag, point_count) on a valid/ready port for the PLL lock stage.
// PARAMETERS
//  DATA_W  32  width of signed i_component / q_component
//  FREQ_W  32  width of dds_freq tuning word
//  CNT_W   16  width of point counter (saturating)
// PORTS
//  clk           in   1         system clock (50 MHz)
//  reset_n       in   1         asynchronous, active-low reset
//  sweep_start   in   1         1-cycle pulse from frequency_sweeper: new sweep begins
//  sweep_done    in   1         level/pulse from frequency_sweeper: sweep finished
//  dds_freq      in   FREQ_W    current DDS tuning word
//  data_valid    in   1         phase_detector result strobe (1 cycle)
//  i_component   in   DATA_W    signed in-phase result
//  q_component   in   DATA_W    signed quadrature result
//  result_valid  out  1         summary record available
//  result_ready  in   1         consumer accepts record
//  peak_freq     out  FREQ_W    tuning word at peak magnitude
//  peak_mag      out  DATA_W+1  peak magnitude approximation
//  point_count   out  CNT_W     points accumulated this sweep
//  busy          out  1         high in SWEEP, DRAIN or REPORT
// BEHAVIOUR
//  Reset (reset_n=0, async): state IDLE; all outputs and internal regs 0.
//  FSM states:
//  - IDLE: sweep_start -> SWEEP; clear peak_mag, peak_freq and point_count.
//  - SWEEP: each data_valid feeds stage 1. sweep_done -> DRAIN. sweep_start re-clears stats, stays in SWEEP.
//  - DRAIN: one cycle, lets stage-2 compare complete; -> REPORT.
//  - REPORT: result_valid=1. Outputs held stable until result_ready=1 sampled at a rising edge, then -> IDLE.
//    sweep_start and data_valid are ignored in REPORT.
//  Datapath pipeline (2 cycles from data_valid to peak update):
//  - Stage 1 registers a=|I| and b=|Q| plus dds_freq sampled on the same edge.
//    abs(-2^(DATA_W-1)) saturates to 2^(DATA_W-1)-1.
//  - Stage 2: mag = max(a,b) + (min(a,b)>>1), unsigned DATA_W+1 bits, no overflow.
//    If mag > peak_mag (strict), update peak_mag and peak_freq. Ties keep the earlier (lower-index) point.
//    point_count += 1, saturating at 2^CNT_W-1.
//  - data_valid in the same cycle as sweep_done is still counted (pipeline drains in DRAIN).
//  - Zero points in a sweep: REPORT with point_count=0, peak_mag=0, peak_freq=0.
//  - First point always becomes the peak (peak_mag cleared to 0, and mag=0 does not update, so peak_freq stays 0).
//  - Reset asserted mid-sweep or mid-REPORT: immediate return to IDLE, record lost, result_valid=0.
//  busy = (state != IDLE). result_valid is registered and is never combinationally dependent on result_ready.
// CONFIGURATION
//  PEAK_THRESHOLD_EN defined:
//  - Adds input mag_threshold [DATA_W:0] and output peak_found [1].
//  - Stage 2 considers a point for the peak only if mag >= mag_threshold. point_count still counts every point.
//  - peak_found = 1 in REPORT iff at least one point passed the threshold, else 0 (peak_freq/peak_mag then 0).
//  - peak_found resets to 0 and clears on sweep_start.
//  PEAK_THRESHOLD_EN undefined: neither port exists; every point is a peak candidate.
// TESTING
//  1. Reset: reset_n=0 -> result_valid=0, busy=0, peak_*=0, point_count=0.
//  2. Single peak: sweep_start, then 5 points (I,Q)=(10,0),(30,-40),(100,20),(-60,60),(5,5)
//     with dds_freq 0x01000000+k*0x00010000, k=0..4, then sweep_done
//     -> peak_mag=110, peak_freq=0x01020000, point_count=5, result_valid held until result_ready.
//  3. Tie: points mag 50 at freq A, then 50 at freq B -> peak_freq=A.
//  4. Extremes: I=0x80000000, Q=0x80000000 -> peak_mag=0x7FFFFFFF+0x3FFFFFFF=0x0BFFFFFFE, no wrap.
//  5. Boundary: data_valid coincident with sweep_done counted.
//     sweep_done with zero points -> point_count=0, peak_mag=0.
//     reset_n=0 during REPORT -> result_valid=0 next edge, busy=0.
//  6. PEAK_THRESHOLD_EN, mag_threshold=200, max point mag 110 -> peak_found=0, peak_mag=0, point_count=5.

Source files
------------

// File: rtl/sweep_peak_detector.sv
// ----------------------------------------------------------------------------
// sweep_peak_detector
// Tracks the peak magnitude, max(|I|,|Q|) + min(|I|,|Q|)/2, over one
// frequency sweep and the DDS tuning word where it occurred. At sweep end it
// presents one summary record on a valid/ready port.
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   sweep_start, sweep_done      sweep control from the frequency sweeper
//   dds_freq                     current DDS tuning word
//   data_valid, i_component,     phase detector result strobe and signed I/Q
//   q_component
//   result_valid, result_ready   summary record handshake
//   peak_freq, peak_mag,         summary record payload
//   point_count
//   busy                         high while not IDLE
//
// Optional feature, macro PEAK_THRESHOLD_EN:
//   mag_threshold (in)           minimum magnitude for a peak candidate
//   peak_found (out)             at least one point passed the threshold
// ----------------------------------------------------------------------------
module sweep_peak_detector #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned FREQ_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sweep_start,
  input  logic                     sweep_done,
  input  logic [FREQ_W-1:0]        dds_freq,
  input  logic                     data_valid,
  input  logic signed [DATA_W-1:0] i_component,
  input  logic signed [DATA_W-1:0] q_component,
`ifdef PEAK_THRESHOLD_EN
  input  logic [DATA_W:0]          mag_threshold,
  output logic                     peak_found,
`endif
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic [FREQ_W-1:0]        peak_freq,
  output logic [DATA_W:0]          peak_mag,
  output logic [CNT_W-1:0]         point_count,
  output logic                     busy
);

  localparam int unsigned MAG_W = DATA_W + 1;
  localparam logic [DATA_W-1:0] ABS_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] NEG_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SWEEP  = 2'd1,
    S_DRAIN  = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;
  logic   w_clear;
  logic   w_capture;

  // Stage 1 registers
  logic              r_s1_valid;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [FREQ_W-1:0] r_freq;

  // Stage 2 combinational magnitude
  logic [DATA_W-1:0] w_max;
  logic [DATA_W-1:0] w_min;
  logic [MAG_W-1:0]  w_mag;
  logic              w_cand;
  logic              w_update;

  // Absolute value; the most negative code saturates instead of wrapping
  function automatic logic [DATA_W-1:0] f_abs_sat(input logic [DATA_W-1:0] x);
    if (!x[DATA_W-1]) begin
      return x;
    end else if (x == NEG_MIN) begin
      return ABS_MAX;
    end else begin
      return DATA_W'(~x + 1'b1);
    end
  endfunction

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and sweep control strobes
  always_comb begin
    w_next_state = r_state;
    w_clear      = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (sweep_start) begin
          w_next_state = S_SWEEP;
          w_clear      = 1'b1;
        end
      end
      S_SWEEP: begin
        w_clear   = sweep_start;
        w_capture = data_valid;
        if (sweep_done) begin
          w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_next_state = S_REPORT;
      end
      S_REPORT: begin
        if (result_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Registered status outputs, aligned with the state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      result_valid <= (w_next_state == S_REPORT);
      busy         <= (w_next_state != S_IDLE);
    end
  end

  // Stage 1: absolute values and the tuning word of the same sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_freq     <= '0;
    end else begin
      r_s1_valid <= w_capture;
      if (w_capture) begin
        r_a    <= f_abs_sat(i_component);
        r_b    <= f_abs_sat(q_component);
        r_freq <= dds_freq;
      end
    end
  end

  // Stage 2 magnitude and peak compare
  always_comb begin
    w_max  = r_b;
    w_min  = r_a;
    if (r_a >= r_b) begin
      w_max = r_a;
      w_min = r_b;
    end
    w_mag  = MAG_W'(w_max) + MAG_W'(w_min >> 1);
    w_cand = r_s1_valid;
`ifdef PEAK_THRESHOLD_EN
    w_cand = r_s1_valid && (w_mag >= mag_threshold);
`endif
    // Strict compare: ties keep the earlier point
    w_update = w_cand && (w_mag > peak_mag);
  end

  // Stage 2 statistics; a new sweep_start discards any in-flight point
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      peak_mag    <= '0;
      peak_freq   <= '0;
      point_count <= '0;
`ifdef PEAK_THRESHOLD_EN
      peak_found  <= 1'b0;
`endif
    end else if (w_clear) begin
      peak_mag    <= '0;
      peak_freq   <= '0;
      point_count <= '0;
`ifdef PEAK_THRESHOLD_EN
      peak_found  <= 1'b0;
`endif
    end else if (r_s1_valid) begin
      if (point_count != CNT_MAX) begin
        point_count <= point_count + 1'b1;
      end
      if (w_update) begin
        peak_mag  <= w_mag;
        peak_freq <= r_freq;
      end
`ifdef PEAK_THRESHOLD_EN
      if (w_cand) begin
        peak_found <= 1'b1;
      end
`endif
    end
  end

endmodule
